// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM state encoding,
// RV32I funct3 width codes, and the access-size decode used by both the
// control path and the lane aligner.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        STORE  = 3'd3,
        RESP   = 3'd4
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Access width for a request. Any funct3 without a defined meaning for
    // the given direction falls back to a whole-word access.
    function automatic lsu_size_t access_size(input logic is_store, input logic [2:0] funct3);
        lsu_size_t sz;
        sz = SZ_WORD;
        if (is_store) begin
            if (funct3 == F3_SB)
                sz = SZ_BYTE;
            else if (funct3 == F3_SH)
                sz = SZ_HALF;
        end else begin
            if (funct3 == F3_LB || funct3 == F3_LBU)
                sz = SZ_BYTE;
            else if (funct3 == F3_LH || funct3 == F3_LHU)
                sz = SZ_HALF;
        end
        return sz;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Bundle of the execute-stage request/response handshake and the word-wide
// data-memory port. The slave modport is the load/store unit's view; the
// master modport is the surrounding core plus memory.
interface lsu_if #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_err;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and sign/zero-extends a byte or
// halfword for loads, and merges store data into the old word for stores.
// Halfword lanes use addr_lo[1] only; addr_lo[0] is ignored for halfwords.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] sdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);
    logic [7:0]  lbyte;
    logic [15:0] lhalf;
    logic        ext_sign;
    logic [3:0]  lane_mask;
    logic [31:0] lane_data;

    // Load path: pick the addressed lane and extend it to 32 bits.
    always_comb begin
        lbyte     = word[7:0];
        lhalf     = addr_lo[1] ? word[31:16] : word[15:0];
        ext_sign  = ~funct3[2];
        load_data = word;
        case (addr_lo)
            2'd0:    lbyte = word[7:0];
            2'd1:    lbyte = word[15:8];
            2'd2:    lbyte = word[23:16];
            default: lbyte = word[31:24];
        endcase
        case (access_size(1'b0, funct3))
            SZ_BYTE: load_data = {{24{ext_sign & lbyte[7]}}, lbyte};
            SZ_HALF: load_data = {{16{ext_sign & lhalf[15]}}, lhalf};
            default: load_data = word;
        endcase
    end

    // Store path: replicate the store data across lanes and build a lane mask.
    always_comb begin
        lane_mask = 4'b1111;
        lane_data = sdata;
        case (access_size(1'b1, funct3))
            SZ_BYTE: begin
                lane_mask = 4'b0001 << addr_lo;
                lane_data = {4{sdata[7:0]}};
            end
            SZ_HALF: begin
                lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{sdata[15:0]}};
            end
            default: begin
                lane_mask = 4'b1111;
                lane_data = sdata;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_merge
            assign store_word[8*gi +: 8] = lane_mask[gi] ? lane_data[8*gi +: 8] : word[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit driving a word-wide memory with combinational read
// and synchronous whole-word write. Sub-word stores are read-modify-write.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- misaligned halfword/word
// accesses skip memory and respond with resp_err=1. XLEN must be 32.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);
    lsu_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic              we_reg;
    logic [2:0]        funct3_reg;
    logic [XLEN-1:0]   wdata_reg;
    logic [XLEN-1:0]   merge_reg;
    logic [XLEN-1:0]   resp_rdata_reg;
    logic              accept;
    lsu_size_t         req_size;
    logic [XLEN-1:0]   align_word;
    logic [XLEN-1:0]   load_data;
    logic [XLEN-1:0]   store_word;

    assign accept   = bus.req_valid && (state_reg == IDLE);
    assign req_size = access_size(bus.req_we, bus.req_funct3);

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign;
    logic resp_err_reg;
    assign misalign = ((req_size == SZ_HALF) && bus.req_addr[0]) ||
                      ((req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
    assign bus.resp_err = resp_err_reg;
`else
    assign bus.resp_err = 1'b0;
`endif

    // Loads extract from live memory data; stores merge into the captured old word.
    assign align_word = we_reg ? merge_reg : bus.mem_rdata;

    lsu_lane_align u_align (
        .word       (align_word),
        .addr_lo    (addr_reg[1:0]),
        .funct3     (funct3_reg),
        .sdata      (wdata_reg),
        .load_data  (load_data),
        .store_word (store_word)
    );

    assign bus.mem_addr   = {addr_reg[ADDR_W-1:2], 2'b00};
    assign bus.mem_wdata  = (state_reg == STORE) ? store_word : '0;
    assign bus.resp_rdata = resp_rdata_reg;

    // Next-state and handshake/strobe decode; all outputs are pure state decodes.
    always_comb begin
        state_next     = state_reg;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.mem_we     = 1'b0;
        case (state_reg)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (!bus.req_we)
                        state_next = LOAD;
                    else if (req_size == SZ_WORD)
                        state_next = STORE;
                    else
                        state_next = RMW_RD;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (misalign)
                        state_next = RESP;
`endif
                end
            end
            LOAD:   state_next = RESP;
            RMW_RD: state_next = STORE;
            STORE: begin
                bus.mem_we = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Latch the request on the accept edge; held for the whole transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg   <= '0;
            we_reg     <= 1'b0;
            funct3_reg <= 3'b000;
            wdata_reg  <= '0;
        end else if (accept) begin
            addr_reg   <= bus.req_addr;
            we_reg     <= bus.req_we;
            funct3_reg <= bus.req_funct3;
            wdata_reg  <= bus.req_wdata;
        end
    end

    // Capture the old word during the read half of a read-modify-write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            merge_reg <= '0;
        else if (state_reg == RMW_RD)
            merge_reg <= bus.mem_rdata;
    end

    // Response data: load result, or zero for stores and trapped accesses; held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            resp_rdata_reg <= '0;
        else if (state_reg == LOAD)
            resp_rdata_reg <= load_data;
        else if (state_reg == STORE)
            resp_rdata_reg <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
        else if (accept && misalign)
            resp_rdata_reg <= '0;
`endif
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // Error flag is decided at accept and stays valid through the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            resp_err_reg <= 1'b0;
        else if (accept)
            resp_err_reg <= misalign;
    end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural word memory.
// Expected responses are queued when a request is driven and compared when
// resp_valid is seen; latency, write counts and ready behaviour are checked
// per transaction. Honours LSU_MISALIGN_TRAP_EN.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_if #(.ADDR_W(32), .XLEN(32)) bus ();

    load_store_unit #(.ADDR_W(32), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural memory: combinational read, synchronous write, bench preload port.
    logic [31:0] mem [0:63];
    logic        pre_we;
    logic [5:0]  pre_idx;
    logic [31:0] pre_val;

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_idx] <= pre_val;
        else if (bus.mem_we)
            mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       tag;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          wcount = 0;
    logic [31:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;

    // Monitor: count write pulses and score each response against the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_we) begin
                wcount++;
                last_waddr = bus.mem_addr;
                last_wdata = bus.mem_wdata;
            end
            if (bus.resp_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk({mon_e.tag, "_rdata"}, bus.resp_rdata, mon_e.rdata);
                    chk({mon_e.tag, "_err"}, {31'd0, bus.resp_err}, {31'd0, mon_e.err});
                    $display("resp %s rdata=%h err=%0d", mon_e.tag, bus.resp_rdata, bus.resp_err);
                end
            end
        end
    end

    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        @(negedge clk);
        pre_we  = 1'b1;
        pre_idx = idx;
        pre_val = val;
        @(negedge clk);
        pre_we  = 1'b0;
    endtask

    // Drive one request (caller is at a negedge), wait for its response and
    // check latency, write count and ready behaviour. With hold=1 req_valid
    // stays high so the next call chains back-to-back.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input int exp_lat, input int exp_wr, input bit hold);
        exp_t e;
        int   w0;
        int   lat;
        int   n;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.tag   = tag;
        sb_q.push_back(e);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        w0 = wcount;
        @(posedge clk);
        @(negedge clk);
        if (!hold)
            bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 20) begin
            chk({tag, "_ready_busy"}, {31'd0, bus.req_ready}, 32'd0);
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_ready_in_resp"}, {31'd0, bus.req_ready}, 32'd0);
        chk({tag, "_writes"}, wcount - w0, exp_wr);
        $display("req %s we=%0d f3=%0d addr=%h wdata=%h lat=%0d", tag, we, f3, addr, wd, lat);
    endtask

    int w_save;

    initial begin
        rst            = 1'b1;
        pre_we         = 1'b0;
        pre_idx        = '0;
        pre_val        = '0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        repeat (3) @(negedge clk);

        chk("rst_req_ready",  {31'd0, bus.req_ready},  32'd1);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata,          32'd0);
        chk("rst_resp_err",   {31'd0, bus.resp_err},   32'd0);
        chk("rst_mem_we",     {31'd0, bus.mem_we},     32'd0);
        chk("rst_mem_addr",   bus.mem_addr,            32'd0);
        chk("rst_mem_wdata",  bus.mem_wdata,           32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Word store then load back.
        do_req("sw10", 1'b1, F3_SW, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 1'b0);
        chk("sw10_waddr", last_waddr, 32'h10);
        chk("sw10_wdata", last_wdata, 32'hDEADBEEF);
        do_req("lw10", 1'b0, F3_LW, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, 1'b0);

        // Sub-word loads with sign/zero extension.
        preload(6'd8, 32'h80FF7F01);
        do_req("lb21",  1'b0, F3_LB,  32'h21, 32'h0, 32'h0000007F, 1'b0, 2, 0, 1'b0);
        do_req("lb23",  1'b0, F3_LB,  32'h23, 32'h0, 32'hFFFFFF80, 1'b0, 2, 0, 1'b0);
        do_req("lbu22", 1'b0, F3_LBU, 32'h22, 32'h0, 32'h000000FF, 1'b0, 2, 0, 1'b0);
        do_req("lh22",  1'b0, F3_LH,  32'h22, 32'h0, 32'hFFFF80FF, 1'b0, 2, 0, 1'b0);
        do_req("lhu20", 1'b0, F3_LHU, 32'h20, 32'h0, 32'h00007F01, 1'b0, 2, 0, 1'b0);
        do_req("lf3_011", 1'b0, 3'b011, 32'h20, 32'h0, 32'h80FF7F01, 1'b0, 2, 0, 1'b0);

        // Read-modify-write byte and halfword stores.
        preload(6'd12, 32'h11223344);
        do_req("sb31", 1'b1, F3_SB, 32'h31, 32'h123456AA, 32'h0, 1'b0, 3, 1, 1'b0);
        chk("sb31_waddr", last_waddr, 32'h30);
        chk("sb31_wdata", last_wdata, 32'h1122AA44);
        do_req("sh32", 1'b1, F3_SH, 32'h32, 32'h5555BEEF, 32'h0, 1'b0, 3, 1, 1'b0);
        chk("sh32_wdata", last_wdata, 32'hBEEFAA44);
        do_req("lw30", 1'b0, F3_LW, 32'h30, 32'h0, 32'hBEEFAA44, 1'b0, 2, 0, 1'b0);

        // Back-to-back with req_valid held high throughout.
        do_req("b2b_lw10",  1'b0, F3_LW,  32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, 1'b1);
        do_req("b2b_lbu23", 1'b0, F3_LBU, 32'h23, 32'h0, 32'h00000080, 1'b0, 2, 0, 1'b1);
        do_req("b2b_sw40",  1'b1, F3_SW,  32'h40, 32'h12345678, 32'h0, 1'b0, 2, 1, 1'b1);
        do_req("b2b_lw40",  1'b0, F3_LW,  32'h40, 32'h0, 32'h12345678, 1'b0, 2, 0, 1'b0);

        // Reset during the read phase of a byte store: abandoned, memory untouched.
        @(negedge clk);
        w_save         = wcount;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = F3_SB;
        bus.req_addr   = 32'h41;
        bus.req_wdata  = 32'h00000099;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_req_ready",  {31'd0, bus.req_ready},  32'd1);
        chk("midrst_mem_we",     {31'd0, bus.mem_we},     32'd0);
        chk("midrst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("midrst_mem_addr",   bus.mem_addr,            32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_writes", wcount - w_save, 32'd0);
        chk("midrst_mem40",  mem[16], 32'h12345678);
        $display("req midrst_sb41 abandoned by reset");
        do_req("lw40_after_rst", 1'b0, F3_LW, 32'h40, 32'h0, 32'h12345678, 1'b0, 2, 0, 1'b0);

        // Misaligned word load.
        preload(6'd1, 32'hCAFEF00D);
`ifdef LSU_MISALIGN_TRAP_EN
        do_req("lw05", 1'b0, F3_LW, 32'h05, 32'h0, 32'h0, 1'b1, 1, 0, 1'b0);
`else
        do_req("lw05", 1'b0, F3_LW, 32'h05, 32'h0, 32'hCAFEF00D, 1'b0, 2, 0, 1'b0);
`endif

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
